// File: rtl/mul_div_if.sv
// mul_div_if: control-side bundle for the multiply/divide unit.
//
// Handshake: the controller raises start for one cycle, with op/a/b valid
// in that cycle, and only while busy=0; a start seen while busy=1 is
// dropped. busy stays high until the result is written. done is a
// one-cycle pulse in the first cycle where the new hi/lo values are visible.
// hi_we/lo_we write wdata into HI/LO only while busy=0.
//
// Signals:
//   start  ctrl -> unit   launch an operation
//   op     ctrl -> unit   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   ctrl -> unit   rs / rt operands
//   hi_we  ctrl -> unit   MTHI write enable
//   lo_we  ctrl -> unit   MTLO write enable
//   wdata  ctrl -> unit   MTHI/MTLO data
//   busy   unit -> ctrl   operation in progress
//   done   unit -> ctrl   result just written
//   hi, lo unit -> ctrl   architectural HI/LO registers
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine holding HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          mul_div_if slave (start/op/a/b, MTHI/MTLO writes, busy/done/hi/lo)
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// The unit works on operand magnitudes: one shift-add (multiply) or one
// restoring shift-subtract (divide) step per cycle for WIDTH cycles, then a
// FIX cycle applies the signs and writes HI/LO.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    mul_div_if.slave   bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;       // raw dividend, returned in HI on divide-by-zero
    logic               div0_q;
    logic               neg_lo_q;  // negate product / quotient
    logic               neg_hi_q;  // negate remainder (dividend sign)
    logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_q;    // {upper, lower}: product or {remainder, quotient}
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [WIDTH:0]     mul_sum_d;
    logic [WIDTH:0]     div_shift_d;
    logic               div_ge_d;
    logic [WIDTH:0]     div_rem_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] prod_neg_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   fix_hi_d;
    logic [WIDTH-1:0]   fix_lo_d;
    logic               signed_op_d;

    always_comb begin
        signed_op_d = ~bus.op[0];
        abs_a_d     = (signed_op_d && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b_d     = (signed_op_d && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply step: add multiplicand into the upper half when the
        // current multiplier bit (LSB) is set, then shift right by one.
        mul_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

        // Divide step: shift the next dividend bit into the remainder and
        // subtract the divisor if it fits; the quotient bit enters at the LSB.
        div_shift_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge_d    = (div_shift_d >= {1'b0, opnd_q});
        div_rem_d   = div_ge_d ? (div_shift_d - {1'b0, opnd_q}) : div_shift_d;

        if (op_q[1]) begin
            prod_d = {div_rem_d[WIDTH-1:0], prod_q[WIDTH-2:0], div_ge_d};
        end else begin
            prod_d = {mul_sum_d, prod_q[WIDTH-1:1]};
        end

        prod_neg_d = -prod_q;
        quo_d      = neg_lo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_d      = neg_hi_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

        if (!op_q[1]) begin
            {fix_hi_d, fix_lo_d} = neg_lo_q ? prod_neg_d : prod_q;
        end else if (div0_q) begin
            fix_hi_d = a_q;
            fix_lo_d = '1;
        end else begin
            fix_hi_d = rem_d;
            fix_lo_d = quo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // MTHI/MTLO land even when start is taken on the same edge;
                    // the result written at FIX overwrites them.
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_q      <= bus.a;
                        div0_q   <= (bus.b == '0);
                        neg_lo_q <= signed_op_d && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_hi_q <= signed_op_d && bus.a[WIDTH-1];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                        if (bus.op[1]) begin
                            opnd_q <= abs_b_d;
                            prod_q <= {{WIDTH{1'b0}}, abs_a_d};
                        end else begin
                            opnd_q <= abs_a_d;
                            prod_q <= {{WIDTH{1'b0}}, abs_b_d};
                        end
                    end
                end
                RUN: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // driver: called #1 after a rising edge; start is sampled at the next edge
  task automatic issue(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.a     = a_v;
    bus.b     = b_v;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // driver: counts busy cycles from the current sample until busy drops
  task automatic wait_done(output int cycles, output logic saw_done);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
    end
    saw_done = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu();
    int   cyc;
    logic dn;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL multu_busy_start: busy=%b expected 1", bus.busy);
    end
    wait_done(cyc, dn);
    checks++;
    if (cyc != 33) begin
      errors++; $display("FAIL multu_latency: busy cycles=%0d expected 33", cyc);
    end
    checks++;
    if (dn !== 1'b1) begin
      errors++; $display("FAIL multu_done: done=%b expected 1", dn);
    end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h expected fffffffe 00000001", bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL multu_done_pulse: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_mult();
    int   cyc;
    logic dn;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc, dn);
    checks++;
    if (dn !== 1'b1 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg: done=%b hi=%h lo=%h expected 1 ffffffff fffffff1", dn, bus.hi, bus.lo);
    end
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc, dn);
    checks++;
    if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0000_0000) begin
      errors++; $display("FAIL mult_minmin: hi=%h lo=%h expected 40000000 00000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int   cyc;
    logic dn;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, dn);
    checks++;
    if (dn !== 1'b1 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: done=%b lo=%h hi=%h expected 1 fffffffd ffffffff", dn, bus.lo, bus.hi);
    end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc, dn);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'h0000_0001) begin
      errors++; $display("FAIL div_negdivisor: lo=%h hi=%h expected fffffffd 00000001", bus.lo, bus.hi);
    end
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    wait_done(cyc, dn);
    checks++;
    if (bus.lo !== 32'h5555_5555 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL divu_big: lo=%h hi=%h expected 55555555 00000000", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_corner();
    int   cyc;
    logic dn;
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done(cyc, dn);
    checks++;
    if (dn !== 1'b1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd100) begin
      errors++; $display("FAIL divu_by_zero: done=%b lo=%h hi=%h expected 1 ffffffff 00000064", dn, bus.lo, bus.hi);
    end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc, dn);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9) begin
      errors++; $display("FAIL div_by_zero_signed: lo=%h hi=%h expected ffffffff fffffff9", bus.lo, bus.hi);
    end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, dn);
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow: lo=%h hi=%h expected 80000000 00000000", bus.lo, bus.hi);
    end
  endtask

  task automatic test_ignored_while_busy();
    int   cyc;
    logic dn;
    issue(OP_DIVU, 32'd7, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd5;
    bus.b     = 32'd9;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(cyc, dn);
    checks++;
    if (cyc != 23 || dn !== 1'b1) begin
      errors++; $display("FAIL busy_ignore_timing: remaining busy=%0d done=%b expected 23 1", cyc, dn);
    end
    checks++;
    if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
      errors++; $display("FAIL busy_ignore_result: lo=%h hi=%h expected 00000003 00000001", bus.lo, bus.hi);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_no_replay: busy=%b expected 0", bus.busy);
    end
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.lo !== 32'h0000_1234 || bus.hi !== 32'd1) begin
      errors++; $display("FAIL mtlo_idle: lo=%h hi=%h expected 00001234 00000001", bus.lo, bus.hi);
    end
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.lo !== 32'hCAFE_0001 || bus.hi !== 32'hCAFE_0001) begin
      errors++; $display("FAIL mthi_mtlo_both: lo=%h hi=%h expected cafe0001 cafe0001", bus.lo, bus.hi);
    end
  endtask

  task automatic test_write_with_start();
    int   cyc;
    logic dn;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h0000_ABCD || bus.busy !== 1'b1) begin
      errors++; $display("FAIL write_with_start: hi=%h busy=%b expected 0000abcd 1", bus.hi, bus.busy);
    end
    wait_done(cyc, dn);
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      errors++; $display("FAIL write_with_start_result: hi=%h lo=%h expected 00000000 00000006", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int   cyc;
    logic dn;
    logic any_done;
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) any_done = 1'b1;
    end
    checks++;
    if (any_done !== 1'b0) begin
      errors++; $display("FAIL reset_abandon: activity seen=%b expected 0", any_done);
    end
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done(cyc, dn);
    checks++;
    if (cyc != 33 || dn !== 1'b1 || bus.lo !== 32'd42 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL restart_after_reset: cycles=%0d done=%b lo=%h hi=%h expected 33 1 0000002a 00000000", cyc, dn, bus.lo, bus.hi);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_ignored_while_busy();
    test_write_with_start();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
